// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: depth/pointer sizing, flag bundle
// and read-mode selectors.
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic int fifo_depth(input int a_size);
        return 1 << a_size;
    endfunction

    // Pointers carry one extra wrap bit above the memory index.
    function automatic int fifo_ptr_width(input int a_size);
        return a_size + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

endpackage

// File: rtl/fifo_mem_sp.sv
// Register-file storage: registered write port, asynchronous read port.
// Contents are deliberately not reset.
module fifo_mem_sp #(
    parameter int D_SIZE = 8,
    parameter int A_SIZE = 3
) (
    input  logic              CLK,
    input  logic              WE,
    input  logic [A_SIZE-1:0] WADDR,
    input  logic [D_SIZE-1:0] WDATA,
    input  logic [A_SIZE-1:0] RADDR,
    output logic [D_SIZE-1:0] RDATA
);

    logic [D_SIZE-1:0] mem [2**A_SIZE];

    always_ff @(posedge CLK) begin
        if (WE) begin
            mem[WADDR] <= WDATA;
        end
    end

    assign RDATA = mem[RADDR];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with occupancy count, threshold flags, sticky error flags
// and a selectable standard / first-word-fall-through read port.
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int D_SIZE   = 8,
    parameter int A_SIZE   = 3,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              W_INC,
    input  logic [D_SIZE-1:0] WR_DATA,
    input  logic              R_INC,
    input  logic              CLR_ERR,
    output logic [D_SIZE-1:0] RD_DATA,
    output logic              RD_VALID,
    output logic              FULL,
    output logic              EMPTY,
    output logic              ALMOST_FULL,
    output logic              ALMOST_EMPTY,
    output logic [A_SIZE:0]   COUNT,
    output logic              OVERFLOW,
    output logic              UNDERFLOW
);

    localparam int PW = fifo_ptr_width(A_SIZE);
    localparam logic [PW-1:0] DEPTH_CNT = PW'(fifo_depth(A_SIZE));
    localparam logic [PW-1:0] AF_CNT    = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_CNT    = PW'(AE_LEVEL);

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     count_q;
    logic              overflow_q;
    logic              underflow_q;
    logic              wr_acc;
    logic              rd_acc;
    logic [D_SIZE-1:0] mem_rdata;
    fifo_flags_t       flags;

    // Flags decode only the registered count, so they never glitch.
    assign flags.full         = (count_q == DEPTH_CNT);
    assign flags.empty        = (count_q == '0);
    assign flags.almost_full  = (count_q >= AF_CNT);
    assign flags.almost_empty = (count_q <= AE_CNT);

    // No bypass: a full FIFO rejects writes even when a read is accepted.
    assign wr_acc = W_INC && !flags.full;
    assign rd_acc = R_INC && !flags.empty;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_acc && !rd_acc) begin
                count_q <= count_q + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                count_q <= count_q - 1'b1;
            end
            // Set beats clear when both happen in the same cycle.
            if (W_INC && flags.full) begin
                overflow_q <= 1'b1;
            end else if (CLR_ERR) begin
                overflow_q <= 1'b0;
            end
            if (R_INC && flags.empty) begin
                underflow_q <= 1'b1;
            end else if (CLR_ERR) begin
                underflow_q <= 1'b0;
            end
        end
    end

    // The pointer distance must always agree with the tracked occupancy.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            assert (count_q == PW'(wr_ptr - rd_ptr));
        end
    end

    fifo_mem_sp #(
        .D_SIZE(D_SIZE),
        .A_SIZE(A_SIZE)
    ) u_mem (
        .CLK  (CLK),
        .WE   (wr_acc),
        .WADDR(wr_ptr[A_SIZE-1:0]),
        .WDATA(WR_DATA),
        .RADDR(rd_ptr[A_SIZE-1:0]),
        .RDATA(mem_rdata)
    );

    generate
        if (FWFT == FIFO_STD) begin : g_std
            logic [D_SIZE-1:0] rd_data_q;
            logic              rd_valid_q;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) begin
                        rd_data_q <= mem_rdata;
                    end
                end
            end

            assign RD_DATA  = rd_data_q;
            assign RD_VALID = rd_valid_q;
        end else begin : g_fwft
            // Head word is shown before the pop; R_INC consumes it.
            assign RD_DATA  = mem_rdata;
            assign RD_VALID = !flags.empty;
        end
    endgenerate

    assign FULL         = flags.full;
    assign EMPTY        = flags.empty;
    assign ALMOST_FULL  = flags.almost_full;
    assign ALMOST_EMPTY = flags.almost_empty;
    assign COUNT        = count_q;
    assign OVERFLOW     = overflow_q;
    assign UNDERFLOW    = underflow_q;

endmodule
